regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32×8 register file. It shares the single regfile write port between the ALU writeback path and a byte-wide load-return path, which can arrive late from data memory. After reset it clears all registers to zero with sixteen word writes. It produces the core `stall` for load-use hazards and for load-writeback starvation. It sits between the core's execute/writeback stages and the `regfile` instance and drives that instance's `write`/`write_word`/`d`/`Rd` inputs.

---
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter: reset clear, ALU/load sharing, stall
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_write,
  input  logic        alu_word,
  input  logic [5:0]  alu_d,
  input  logic [15:0] alu_Rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [5:0]  ld_d,
  input  logic [7:0]  ld_Rd,
  input  logic        rd_en,
  input  logic [5:0]  rd_a,
  input  logic        rd_a_word,
  input  logic [5:0]  rd_b,
  output logic        rf_write,
  output logic        rf_write_word,
  output logic [5:0]  rf_d,
  output logic [15:0] rf_Rd,
  output logic        stall,
  output logic        init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [0:0] state_q, state_d;
  logic [3:0] clr_cnt_q, clr_cnt_d;
  logic       pend_valid_q, pend_valid_d;
  logic [5:0] pend_d_q, pend_d_d;
  logic [7:0] pend_rd_q, pend_rd_d;
  logic [3:0] age_q, age_d;

  logic run, hazard, force_wr, drain, accept;

  always_comb begin
    run = (state_q == ST_RUN) && !reset;
    hazard = rd_en && pend_valid_q &&
             ((pend_d_q == rd_a) ||
              (rd_a_word && (pend_d_q == {rd_a[5:1], 1'b1})) ||
              (pend_d_q == rd_b));
    force_wr = run && pend_valid_q && ((age_q >= LIMIT) || hazard);

    rf_write      = 1'b0;
    rf_write_word = 1'b0;
    rf_d          = 6'd0;
    rf_Rd         = 16'd0;
    drain         = 1'b0;

    if (!reset && (state_q == ST_INIT)) begin
      rf_write      = 1'b1;
      rf_write_word = 1'b1;
      rf_d          = {clr_cnt_q, 1'b0};
    end else if (run) begin
      // A forced drain beats the ALU; otherwise the load only fills idle slots.
      if (force_wr || (!alu_write && pend_valid_q)) begin
        rf_write = 1'b1;
        rf_d     = pend_d_q;
        rf_Rd    = {8'h00, pend_rd_q};
        drain    = 1'b1;
      end else if (alu_write) begin
        rf_write      = 1'b1;
        rf_write_word = alu_word;
        rf_d          = alu_d;
        rf_Rd         = alu_Rd;
      end
    end

    stall     = reset || (state_q == ST_INIT) || force_wr;
    ld_ready  = run && (!pend_valid_q || drain);
    accept    = ld_valid && ld_ready;
    init_done = run;
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_d_d     = pend_d_q;
    pend_rd_d    = pend_rd_q;
    age_d        = age_q;

    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + 4'd1;
      if (clr_cnt_q == 4'd15) state_d = ST_RUN;
    end else if (accept) begin
      pend_valid_d = 1'b1;
      pend_d_d     = ld_d;
      pend_rd_d    = ld_Rd;
      age_d        = 4'd0;
    end else if (drain) begin
      pend_valid_d = 1'b0;
      age_d        = 4'd0;
    end else if (pend_valid_q && (age_q != 4'd15)) begin
      age_d = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      clr_cnt_q    <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_d_q     <= 6'd0;
      pend_rd_q    <= 8'd0;
      age_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_d_q     <= pend_d_d;
      pend_rd_q    <= pend_rd_d;
      age_q        <= age_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench for regfile_wb_arbiter against a queue-based model
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_write, alu_word, ld_valid, rd_en, rd_a_word;
  logic [5:0]  alu_d, ld_d, rd_a, rd_b;
  logic [15:0] alu_Rd;
  logic [7:0]  ld_Rd;

  logic        ld_ready, rf_write, rf_write_word, stall, init_done;
  logic [5:0]  rf_d;
  logic [15:0] rf_Rd;

  logic        n_ld_ready, n_rf_write, n_rf_write_word, n_stall, n_init_done;
  logic [5:0]  n_rf_d;
  logic [15:0] n_rf_Rd;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset),
    .alu_write(alu_write), .alu_word(alu_word), .alu_d(alu_d), .alu_Rd(alu_Rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_d(ld_d), .ld_Rd(ld_Rd),
    .rd_en(rd_en), .rd_a(rd_a), .rd_a_word(rd_a_word), .rd_b(rd_b),
    .rf_write(rf_write), .rf_write_word(rf_write_word), .rf_d(rf_d), .rf_Rd(rf_Rd),
    .stall(stall), .init_done(init_done)
  );

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CLEAR_ON_RESET(0)) dut_noclr (
    .clk(clk), .reset(reset),
    .alu_write(alu_write), .alu_word(alu_word), .alu_d(alu_d), .alu_Rd(alu_Rd),
    .ld_valid(ld_valid), .ld_ready(n_ld_ready), .ld_d(ld_d), .ld_Rd(ld_Rd),
    .rd_en(rd_en), .rd_a(rd_a), .rd_a_word(rd_a_word), .rd_b(rd_b),
    .rf_write(n_rf_write), .rf_write_word(n_rf_write_word), .rf_d(n_rf_d), .rf_Rd(n_rf_Rd),
    .stall(n_stall), .init_done(n_init_done)
  );

  always #5 clk = ~clk;

  // Reference model: cycles of clearing left, one-deep pending queue, cycles waited.
  int         init_left = 16;
  int         age = 0;
  logic [5:0] pq_d[$];
  logic [7:0] pq_r[$];
  bit         exp_drain, exp_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit ew, eword, est, edone, pv, hz, frc;
    logic [5:0] ed;
    logic [15:0] er;
    ew = 0; eword = 0; ed = 0; er = 0; est = 1; edone = 0;
    exp_drain = 0; exp_ready = 0;
    if (reset) begin
      est = 1;
    end else if (init_left > 0) begin
      ew = 1; eword = 1; ed = 6'((16 - init_left) * 2); er = 0;
    end else begin
      pv = (pq_d.size() > 0);
      hz = rd_en && pv && (pq_d[0] == rd_a || (rd_a_word && pq_d[0] == (rd_a | 6'd1)) || pq_d[0] == rd_b);
      frc = pv && (age >= LIMIT || hz);
      edone = 1;
      est = frc;
      if (frc || (pv && !alu_write)) begin
        ew = 1; eword = 0; ed = pq_d[0]; er = {8'h00, pq_r[0]}; exp_drain = 1;
      end else if (alu_write) begin
        ew = 1; eword = alu_word; ed = alu_d; er = alu_Rd;
      end
      exp_ready = !pv || exp_drain;
    end
    check("rf_write", 32'(rf_write), 32'(ew));
    if (ew) begin
      check("rf_write_word", 32'(rf_write_word), 32'(eword));
      check("rf_d", 32'(rf_d), 32'(ed));
      check("rf_Rd", 32'(rf_Rd), 32'(er));
    end
    check("stall", 32'(stall), 32'(est));
    check("ld_ready", 32'(ld_ready), 32'(exp_ready));
    check("init_done", 32'(init_done), 32'(edone));
  endtask

  task automatic model_update();
    bit pv;
    if (reset) begin
      init_left = 16; age = 0;
      pq_d.delete(); pq_r.delete();
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      pv = (pq_d.size() > 0);
      if (exp_drain) begin
        void'(pq_d.pop_front()); void'(pq_r.pop_front());
      end
      if (ld_valid && exp_ready) begin
        pq_d.push_back(ld_d); pq_r.push_back(ld_Rd); age = 0;
      end else if (exp_drain) begin
        age = 0;
      end else if (pv && age < 15) begin
        age++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_write = 0; alu_word = 0; alu_d = 0; alu_Rd = 0;
    ld_valid = 0; ld_d = 0; ld_Rd = 0;
    rd_en = 0; rd_a = 0; rd_a_word = 0; rd_b = 6'd63;
  endtask

  task automatic run_random(input int n, input int p_alu, input int p_ld, input int p_rd, input int p_rst);
    for (int i = 0; i < n; i++) begin
      reset     = ($urandom_range(0, 999) < p_rst);
      alu_write = ($urandom_range(0, 99) < p_alu);
      alu_word  = $urandom_range(0, 1);
      alu_d     = 6'($urandom_range(0, 31));
      alu_Rd    = 16'($urandom);
      ld_valid  = ($urandom_range(0, 99) < p_ld);
      ld_d      = 6'($urandom_range(0, 7));
      ld_Rd     = 8'($urandom);
      rd_en     = ($urandom_range(0, 99) < p_rd);
      rd_a      = 6'($urandom_range(0, 7));
      rd_a_word = $urandom_range(0, 1);
      rd_b      = 6'($urandom_range(0, 7));
      cycle();
    end
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    // First cycle out of reset: the no-clear instance is already running.
    reset = 0;
    alu_write = 1; alu_word = 1; alu_d = 6'd2; alu_Rd = 16'h1234;
    #1;
    check("noclr init_done", 32'(n_init_done), 32'd1);
    check("noclr stall", 32'(n_stall), 32'd0);
    check("noclr rf_write", 32'(n_rf_write), 32'd1);
    check("noclr rf_d", 32'(n_rf_d), 32'd2);
    check("noclr rf_Rd", 32'(n_rf_Rd), 32'h1234);
    check("noclr rf_write_word", 32'(n_rf_write_word), 32'd1);
    idle_inputs();
    for (int i = 0; i < 17; i++) cycle();

    // Load d=5 then back-to-back d=6.
    ld_valid = 1; ld_d = 6'd5; ld_Rd = 8'hA7; cycle();
    ld_d = 6'd6; ld_Rd = 8'h3C; cycle();
    ld_valid = 0; cycle(); cycle();

    // Load d=9 under continuous ALU traffic.
    ld_valid = 1; ld_d = 6'd9; ld_Rd = 8'h5A;
    alu_write = 1; alu_d = 6'd12; alu_Rd = 16'hBEEF; cycle();
    ld_valid = 0;
    for (int i = 0; i < 7; i++) cycle();
    alu_write = 0; cycle();

    // Read-pair hazard on d=25, then the non-pair read that must not stall.
    ld_valid = 1; ld_d = 6'd25; ld_Rd = 8'h11; alu_write = 1; cycle();
    ld_valid = 0; rd_en = 1; rd_a = 6'd24; rd_a_word = 1; cycle();
    rd_en = 0; cycle();
    ld_valid = 1; ld_d = 6'd25; ld_Rd = 8'h22; cycle();
    ld_valid = 0; rd_en = 1; rd_a = 6'd24; rd_a_word = 0; cycle();
    idle_inputs(); cycle();

    // Reset with a load pending, then again mid-clear at clr_cnt=7.
    ld_valid = 1; ld_d = 6'd3; ld_Rd = 8'h77; alu_write = 1; cycle();
    idle_inputs(); reset = 1; cycle();
    reset = 0;
    for (int i = 0; i < 7; i++) cycle();
    reset = 1; cycle();
    reset = 0;
    for (int i = 0; i < 18; i++) cycle();

    run_random(1500, 30, 50, 30, 3);
    run_random(1000, 90, 60, 10, 2);
    run_random(1000, 10, 90, 60, 2);
    run_random(500, 100, 80, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
